// File: rtl/fluid_pkg.sv
// Shared types and arithmetic for the fluid mixing pipeline.
package fluid_pkg;

    localparam int CNT_W      = 16;
    localparam int CONC_MAX_W = 16;

    typedef logic [CONC_MAX_W-1:0] conc_t;

    // Rounded (half-up) average, widened by one bit so a+b+1 never overflows.
    function automatic conc_t mix_avg(input conc_t a, input conc_t b);
        return conc_t'((({1'b0, a} + {1'b0, b}) + (CONC_MAX_W + 1)'(1)) >> 1);
    endfunction

endpackage

// File: rtl/fluid_delay_line.sv
// One inlet's serpentine: a MAX_DELAY-deep (valid, conc) shift register with a programmable tap.
module fluid_delay_line #(
    parameter int CONC_W    = 8,
    parameter int MAX_DELAY = 16,
    parameter int DLY_W     = $clog2(MAX_DELAY + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DLY_W-1:0]  dly,
    input  logic              in_valid,
    input  logic [CONC_W-1:0] in_conc,
    output logic              tap_valid,
    output logic [CONC_W-1:0] tap_conc,
    output logic              any_valid
);

    logic [MAX_DELAY-1:0] stage_v;
    logic [CONC_W-1:0]    stage_c [MAX_DELAY];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            stage_v <= '0;
            for (int i = 0; i < MAX_DELAY; i++) stage_c[i] <= '0;
        end else begin
            stage_v[0] <= in_valid;
            stage_c[0] <= in_valid ? in_conc : '0;
            for (int i = 1; i < MAX_DELAY; i++) begin
                stage_v[i] <= stage_v[i-1];
                stage_c[i] <= stage_c[i-1];
            end
        end
    end

    // A delay of zero bypasses the register chain entirely.
    always_comb begin
        tap_valid = in_valid;
        tap_conc  = in_conc;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (dly == DLY_W'(i + 1)) begin
                tap_valid = stage_v[i];
                tap_conc  = stage_c[i];
            end
        end
    end

    assign any_valid = |stage_v;

endmodule

// File: rtl/fluid_mix_pipeline.sv
// Serpentine delays feeding a registered chain of two-input diffusion mixers.
module fluid_mix_pipeline
    import fluid_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int CONC_W      = 8,
    parameter int MAX_DELAY   = 16,
    parameter int DEFAULT_DLY = 1,
    parameter int DLY_W       = $clog2(MAX_DELAY + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(N_CH)-1:0]  cfg_ch,
    input  logic [DLY_W-1:0]         cfg_dly,
    output logic                     cfg_err,
    input  logic                     flush,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*CONC_W-1:0]   in_conc,
    output logic                     out_valid,
    output logic [CONC_W-1:0]        out_conc,
    output logic                     busy,
    output logic [CNT_W-1:0]         out_count
);

    localparam int NS = N_CH - 1;

    logic [DLY_W-1:0]  dly [N_CH];
    logic [N_CH-1:0]   tap_v;
    logic [CONC_W-1:0] tap_c [N_CH];
    logic [N_CH-1:0]   line_busy;
    logic [NS-1:0]     stage_vs;
    logic              cfg_bad;

    for (genvar ch = 0; ch < N_CH; ch++) begin : line
        fluid_delay_line #(
            .CONC_W    (CONC_W),
            .MAX_DELAY (MAX_DELAY),
            .DLY_W     (DLY_W)
        ) u_line (
            .clk       (clk),
            .rst       (rst),
            .clr       (flush),
            .dly       (dly[ch]),
            .in_valid  (in_valid[ch]),
            .in_conc   (in_conc[ch*CONC_W +: CONC_W]),
            .tap_valid (tap_v[ch]),
            .tap_conc  (tap_c[ch]),
            .any_valid (line_busy[ch])
        );
    end

    // Stage 0 merges ch0 and ch1; stage s merges stage s-1 with ch s+1.
    for (genvar s = 0; s < NS; s++) begin : mix
        logic              a_v, b_v, m_v, stage_v;
        logic [CONC_W-1:0] a_c, b_c, m_c, stage_c;

        if (s == 0) begin : g_head
            assign a_v = tap_v[0];
            assign a_c = tap_c[0];
        end else begin : g_chain
            assign a_v = mix[s-1].stage_v;
            assign a_c = mix[s-1].stage_c;
        end
        assign b_v = tap_v[s+1];
        assign b_c = tap_c[s+1];
        assign m_v = a_v | b_v;

        always_comb begin
            m_c = '0;
            if (a_v && b_v)
                m_c = CONC_W'(mix_avg(conc_t'(a_c), conc_t'(b_c)));
            else if (a_v)
                m_c = a_c;
            else if (b_v)
                m_c = b_c;
        end

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                stage_v <= 1'b0;
                stage_c <= '0;
            end else begin
                stage_v <= m_v;
                stage_c <= m_c;
            end
        end

        assign stage_vs[s] = stage_v;
    end

    assign out_valid = mix[NS-1].stage_v;
    assign out_conc  = mix[NS-1].stage_c;
    assign busy      = (|line_busy) | (|stage_vs) | (|in_valid);

    // A plug entering this cycle makes busy high, so a simultaneous write is refused.
    assign cfg_bad = busy || (int'(cfg_ch) >= N_CH) || (int'(cfg_dly) > MAX_DELAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) dly[i] <= DLY_W'(DEFAULT_DLY);
            cfg_err   <= 1'b0;
            out_count <= '0;
        end else begin
            cfg_err <= 1'b0;
            // Flush outranks configuration: a write during flush is dropped silently.
            if (cfg_we && !flush) begin
                if (cfg_bad)
                    cfg_err <= 1'b1;
                else
                    dly[cfg_ch] <= cfg_dly;
            end
            if (out_valid && (out_count != '1))
                out_count <= out_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fluid_mix_pipeline.sv
// Table-driven bench for fluid_mix_pipeline with an outlet scoreboard.
module tb_fluid_mix_pipeline;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [4:0]  cfg_dly = '0;
    logic        cfg_err;
    logic        flush = 1'b0;
    logic [2:0]  in_valid = '0;
    logic [23:0] in_conc = '0;
    logic        out_valid;
    logic [7:0]  out_conc;
    logic        busy;
    logic [15:0] out_count;

    fluid_mix_pipeline dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_dly   (cfg_dly),
        .cfg_err   (cfg_err),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_conc   (in_conc),
        .out_valid (out_valid),
        .out_conc  (out_conc),
        .busy      (busy),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  conc;
    } exp_t;
    exp_t exp_q[$];

    typedef struct packed {
        logic [2:0][4:0] d;
        logic [2:0][7:0] c;
        logic [2:0]      v;
        logic [1:0]      n;
        logic [2:0][4:0] rel;
        logic [2:0][7:0] val;
    } vec_t;
    vec_t vecs [10];

    int n_checks  = 0;
    int n_errs    = 0;
    int exp_count = 0;
    bit mon_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outlet scoreboard: each cycle either the queue head is due or the outlet must be idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && int'(exp_q[0].cyc) == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_valid_due", 32'(out_valid), 1);
                check("out_conc", 32'(out_conc), 32'(e.conc));
                exp_count++;
            end else begin
                check("out_valid_idle", 32'(out_valid), 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int rel, input logic [7:0] v);
        exp_t e;
        e.cyc  = 32'(cyc + rel);
        e.conc = v;
        exp_q.push_back(e);
    endtask

    task automatic cfg_write(input int ch, input int d, input logic exp_err);
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_dly = 5'(d);
        step();
        cfg_we = 1'b0;
        @(negedge clk);
        check("cfg_err", 32'(cfg_err), 32'(exp_err));
        step();
        @(negedge clk);
        check("cfg_err_pulse_end", 32'(cfg_err), 0);
        step();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && (busy || exp_q.size() > 0); i++) step();
        check("drain", 32'(busy || (exp_q.size() != 0)), 0);
        check("out_count", 32'(out_count), 32'(exp_count));
    endtask

    function automatic vec_t mk(input int d0, input int d1, input int d2,
                                input int c0, input int c1, input int c2,
                                input logic [2:0] v, input int n,
                                input int r0, input int x0, input int r1, input int x1,
                                input int r2, input int x2);
        vec_t m;
        m.d[0] = 5'(d0); m.d[1] = 5'(d1); m.d[2] = 5'(d2);
        m.c[0] = 8'(c0); m.c[1] = 8'(c1); m.c[2] = 8'(c2);
        m.v = v;
        m.n = 2'(n);
        m.rel[0] = 5'(r0); m.rel[1] = 5'(r1); m.rel[2] = 5'(r2);
        m.val[0] = 8'(x0); m.val[1] = 8'(x1); m.val[2] = 8'(x2);
        return m;
    endfunction

    task automatic run_vec(input vec_t t);
        for (int ch = 0; ch < 3; ch++) cfg_write(ch, int'(t.d[ch]), 1'b0);
        in_valid = t.v;
        in_conc  = t.c;
        for (int j = 0; j < int'(t.n); j++) expect_out(int'(t.rel[j]), t.val[j]);
        step();
        in_valid = '0;
        in_conc  = '0;
        wait_drain();
    endtask

    initial begin
        #500000;
        n_errs++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        vecs[0] = mk(0, 0, 1, 100, 50, 200, 3'b111, 1, 2, 138, 0, 0, 0, 0);
        vecs[1] = mk(0, 0, 0, 100, 50, 200, 3'b111, 2, 1, 200, 2, 75, 0, 0);
        vecs[2] = mk(0, 0, 0, 255, 254, 0, 3'b011, 1, 2, 255, 0, 0, 0, 0);
        vecs[3] = mk(0, 0, 0, 1, 0, 0, 3'b011, 1, 2, 1, 0, 0, 0, 0);
        vecs[4] = mk(0, 0, 0, 0, 77, 0, 3'b010, 1, 2, 77, 0, 0, 0, 0);
        vecs[5] = mk(2, 3, 1, 10, 20, 30, 3'b111, 3, 2, 30, 4, 10, 5, 20);
        vecs[6] = mk(1, 0, 0, 40, 60, 90, 3'b111, 3, 1, 90, 2, 60, 3, 40);
        vecs[7] = mk(16, 15, 14, 1, 2, 3, 3'b111, 3, 15, 3, 17, 2, 18, 1);
        vecs[8] = mk(1, 1, 2, 200, 100, 51, 3'b111, 1, 3, 101, 0, 0, 0, 0);
        vecs[9] = mk(0, 0, 1, 80, 0, 33, 3'b101, 1, 2, 57, 0, 0, 0, 0);

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_conc", 32'(out_conc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_count", 32'(out_count), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        for (int i = 0; i < 3; i++) check("rst_dly", 32'(dut.dly[i]), 1);
        step();
        mon_en = 1'b1;

        for (int k = 0; k < 10; k++) run_vec(vecs[k]);

        // Config guard
        for (int ch = 0; ch < 3; ch++) cfg_write(ch, 5, 1'b0);
        in_valid = 3'b001;
        in_conc  = 24'd9;
        expect_out(7, 8'd9);
        step();
        in_valid = '0;
        in_conc  = '0;
        cfg_write(1, 3, 1'b1);
        check("guard_dly1_kept", 32'(dut.dly[1]), 5);
        wait_drain();

        in_valid = 3'b100;
        in_conc  = {8'd44, 16'd0};
        cfg_we   = 1'b1;
        cfg_ch   = 2'd0;
        cfg_dly  = 5'd2;
        expect_out(6, 8'd44);
        step();
        in_valid = '0;
        in_conc  = '0;
        cfg_we   = 1'b0;
        @(negedge clk);
        check("cfg_err_same_cycle", 32'(cfg_err), 1);
        step();
        check("guard_dly0_kept", 32'(dut.dly[0]), 5);
        wait_drain();

        cfg_write(0, 17, 1'b1);
        check("range_dly0_kept", 32'(dut.dly[0]), 5);
        cfg_write(3, 1, 1'b1);
        cfg_write(2, 16, 1'b0);
        check("max_dly_accepted", 32'(dut.dly[2]), 16);

        // Flush
        for (int ch = 0; ch < 3; ch++) cfg_write(ch, 5, 1'b0);
        in_valid = 3'b111;
        in_conc  = {8'd30, 8'd20, 8'd10};
        step();
        in_valid = '0;
        in_conc  = '0;
        step();
        flush    = 1'b1;
        in_valid = 3'b100;
        in_conc  = {8'd99, 16'd0};
        @(negedge clk);
        check("busy_before_flush", 32'(busy), 1);
        step();
        flush    = 1'b0;
        in_valid = '0;
        in_conc  = '0;
        @(negedge clk);
        check("busy_after_flush", 32'(busy), 0);
        repeat (20) step();
        check("flush_out_count", 32'(out_count), 32'(exp_count));
        check("flush_keeps_dly", 32'(dut.dly[2]), 5);

        // Reset mid-flight drops the plug
        in_valid = 3'b001;
        in_conc  = 24'd66;
        step();
        in_valid = '0;
        in_conc  = '0;
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_count = 0;
        repeat (25) step();
        check("midrst_out_count", 32'(out_count), 0);
        check("midrst_dly", 32'(dut.dly[0]), 1);
        check("midrst_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/fluid_mix_pipeline.md
# fluid_mix_pipeline

Parametrised cycle-level model of a serpentine-plus-diffusion-mixer network. Each of N_CH inlets carries fluid "plugs": a concentration sample with a valid flag. Each inlet passes through a programmable serpentine delay, then through a linear chain of registered two-input mixers. The block is the successor to the fixed hand-wired serpentine/diffmix netlists. It adds runtime residence-time configuration, flush, and output statistics, and sits between the inlet stimulus drivers and the detector model in the system simulation.

## Interface
- N_CH, 3: inlet count, 2..8
- CONC_W, 8: concentration width, unsigned
- MAX_DELAY, 16: max serpentine delay in cycles, ≥1
- DEFAULT_DLY, 1: per-channel delay after reset, ≤MAX_DELAY
- DLY_W, $clog2(MAX_DELAY+1): derived delay width

- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  delay write strobe
- cfg_ch  in  $clog2(N_CH)  channel to configure
- cfg_dly  in  DLY_W  delay value, 0..MAX_DELAY
- cfg_err  out  1  one-cycle pulse: write rejected
- flush  in  1  purge all in-flight plugs
- in_valid  in  N_CH  per-inlet plug present
- in_conc  in  N_CH*CONC_W  inlet concentrations, channel i at [i*CONC_W +: CONC_W]
- out_valid  out  1  plug at outlet
- out_conc  out  CONC_W  outlet concentration
- busy  out  1  any valid plug in a delay line or mixer register
- out_count  out  16  delivered plugs, saturating

## Operation
- Delay line i: shift register of MAX_DELAY (valid, conc) stages. Tap = dly[i]. dly=0 means a combinational pass-through.
- Mixer stage 1 combines delayed ch0 and ch1. Stage k (2..N_CH-1) combines the stage k-1 register with delayed ch k. Every stage is registered. The last stage drives out_valid/out_conc.
- Mix rule:
  - Both valid: (a+b+1)>>1, computed in CONC_W+1 bits, round half up, no overflow.
  - One valid: pass that value through.
  - Neither valid: valid=0, conc=0.
- The block does not align plugs. Balancing arrival times is the user's job, done through the dly settings, exactly as with physical serpentines.
- Config:
  - cfg_we with busy=0 and in-range cfg_ch and cfg_dly: updates dly[cfg_ch] at the next edge.
  - cfg_we with busy=1, cfg_ch≥N_CH, or cfg_dly>MAX_DELAY: register unchanged, cfg_err=1 next cycle.
  - cfg_we in the same cycle as an accepted in_valid counts as busy, so the write is rejected.
- Flush:
  - Clears every delay-line and mixer valid bit and conc value at the next edge.
  - in_valid sampled in the flush cycle is discarded.
  - dly registers and out_count are kept.
- out_count increments on each out_valid and saturates at 16'hFFFF.

## Timing
- Latency from inlet k to outlet = dly[k] + N_CH − max(k,1) cycles.
- Reset values:
  - out_valid=0, out_conc=0, cfg_err=0, busy=0, out_count=0.
  - All dly=DEFAULT_DLY.
  - All pipeline contents zero.
- Reset applied mid-operation drops all plugs with no outlet activity afterwards.
- Priority order: rst > flush > in_valid/cfg_we.
- busy is combinational OR of all pipeline valid bits plus any in_valid.
- Throughput: one plug per inlet per cycle, no backpressure.

## Structure
- fluid_pkg:
  - conc_t typedef
  - mix_avg function (rounded average)
  - CNT_W=16
- Sub-module fluid_delay_line: one channel's shift register and tap mux, parametrised by CONC_W and MAX_DELAY. Instantiated N_CH times by generate.
- Top level holds the dly register file, the mixer chain (generate loop), flush/cfg control and the counter.

## Test plan
- Reset check: rst for 2 cycles → out_valid=0, out_conc=0, busy=0, out_count=0, all dly=1.
- Balanced mix: N_CH=3, dly={0,0,1}, inject ch0=100, ch1=50, ch2=200 in cycle 0 → out_valid=1 with out_conc=138 in cycle 2 only; out_count=1.
- Unbalanced mix: dly={0,0,0`}`, same injection → cycle 1 out=200, cycle 2 out=75.
- Rounding: ch0=255, ch1=254, ch2 idle, dly=0 → out 255. Repeat with 1 and 0 → out 1.
- Config guard: dly all 5, inject ch0, then cfg_we ch1 dly=3 while busy → cfg_err pulse, dly[1] stays 5. Write cfg_dly=17 when idle → cfg_err. Write cfg_ch=3 → cfg_err.
- Flush: dly all 5, inject all channels, assert flush in cycle 2 → no out_valid for 20 cycles, busy=0 in cycle 3, out_count unchanged.
